// File: rtl/request_unit.sv
// request_unit: sequences instruction/data memory requests for the single-cycle
// datapath, holds a sticky halt and keeps a saturating stall-cycle counter.
module request_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             cu_dREN,
  input  logic             cu_dWEN,
  input  logic             cu_halt,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halt,
  output logic             proto_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DATA = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             dren_q, dren_d;
  logic             dwen_q, dwen_d;
  logic             halt_q, halt_d;
  logic             perr_q, perr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state, latched requests and the combinational PC enable.
  always_comb begin
    state_d = state_q;
    dren_d  = dren_q;
    dwen_d  = dwen_q;
    perr_d  = perr_q;
    pc_en   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        pc_en = ihit & ~cu_halt & ~cu_dREN & ~cu_dWEN;
        if (ihit) begin
          if (cu_halt) begin
            state_d = ST_HALT;
          end else if (cu_dREN | cu_dWEN) begin
            state_d = ST_DATA;
            dren_d  = cu_dREN;
            // A simultaneous load+store is a decoder bug: the read wins.
            dwen_d  = cu_dWEN & ~cu_dREN;
            if (cu_dREN & cu_dWEN) begin
              perr_d = 1'b1;
            end
          end
        end
      end
      ST_DATA: begin
        pc_en = dhit;
        if (dhit) begin
          state_d = ST_RUN;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
        dren_d  = 1'b0;
        dwen_d  = 1'b0;
      end
    endcase
    halt_d = (state_d == ST_HALT);
  end

  // Stall counter: counts non-advancing cycles outside HALT, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != ST_HALT) && !pc_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_RUN;
      dren_q  <= 1'b0;
      dwen_q  <= 1'b0;
      halt_q  <= 1'b0;
      perr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dren_q  <= dren_d;
      dwen_q  <= dwen_d;
      halt_q  <= halt_d;
      perr_q  <= perr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imemREN   = (state_q != ST_HALT);
  assign dmemREN   = dren_q;
  assign dmemWEN   = dwen_q;
  assign halt      = halt_q;
  assign proto_err = perr_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit: a default-width instance and a 4-bit
// counter instance share stimulus; expectations are queued per step and
// compared against the sampled outputs.
module tb_request_unit;

  logic CLK;
  logic nRST;
  logic cu_dREN, cu_dWEN, cu_halt, ihit, dhit;

  logic        imemREN0, dmemREN0, dmemWEN0, pc_en0, halt0, perr0;
  logic [15:0] cnt0;
  logic        imemREN1, dmemREN1, dmemWEN1, pc_en1, halt1, perr1;
  logic [3:0]  cnt1;

  typedef struct packed {
    logic        imem;
    logic        dren;
    logic        dwen;
    logic        pcen;
    logic        hlt;
    logic        perr;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  request_unit #(.CNT_W(16)) u_dut16 (
    .CLK(CLK), .nRST(nRST),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
    .ihit(ihit), .dhit(dhit),
    .imemREN(imemREN0), .dmemREN(dmemREN0), .dmemWEN(dmemWEN0),
    .pc_en(pc_en0), .halt(halt0), .proto_err(perr0), .stall_cnt(cnt0)
  );

  request_unit #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .nRST(nRST),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
    .ihit(ihit), .dhit(dhit),
    .imemREN(imemREN1), .dmemREN(dmemREN1), .dmemWEN(dmemWEN1),
    .pc_en(pc_en1), .halt(halt1), .proto_err(perr1), .stall_cnt(cnt1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t mk(input logic imem, input logic dren, input logic dwen,
                              input logic pcen, input logic hlt, input logic perr,
                              input int cnt, input int cnt4);
    exp_t e;
    e.imem = imem; e.dren = dren; e.dwen = dwen; e.pcen = pcen;
    e.hlt  = hlt;  e.perr = perr;
    e.cnt  = 16'(cnt);
    e.cnt4 = 4'(cnt4);
    return e;
  endfunction

  // Pop the oldest expectation and compare it with both instances.
  task automatic compare(input string tag);
    exp_t e;
    exp_t o;
    logic same_ctl;
    e = exp_q.pop_front();
    same_ctl = (imemREN0 === imemREN1) && (dmemREN0 === dmemREN1) &&
               (dmemWEN0 === dmemWEN1) && (pc_en0 === pc_en1) &&
               (halt0 === halt1) && (perr0 === perr1);
    o.imem = imemREN0; o.dren = dmemREN0; o.dwen = dmemWEN0; o.pcen = pc_en0;
    o.hlt  = halt0;    o.perr = perr0;    o.cnt  = cnt0;     o.cnt4 = cnt1;
    if (!same_ctl) o.imem = ~o.imem ^ e.imem ^ 1'b1 ? o.imem : ~e.imem;
    n_checks++;
    assert (o === e && same_ctl) else begin
      n_err++;
      $error("FAIL %s: observed imem/dren/dwen/pcen/halt/perr=%b%b%b%b%b%b cnt=%0d cnt4=%0d (dut4 ctl %b%b%b%b%b%b) expected %b%b%b%b%b%b cnt=%0d cnt4=%0d",
             tag, o.imem, o.dren, o.dwen, o.pcen, o.hlt, o.perr, o.cnt, o.cnt4,
             imemREN1, dmemREN1, dmemWEN1, pc_en1, halt1, perr1,
             e.imem, e.dren, e.dwen, e.pcen, e.hlt, e.perr, e.cnt, e.cnt4);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge, check at the falling
  // edge, then advance to just after the next rising edge.
  task automatic cycle(input string tag, input logic ih, input logic dh,
                       input logic dr, input logic dw, input logic hl, input exp_t e);
    ihit = ih; dhit = dh; cu_dREN = dr; cu_dWEN = dw; cu_halt = hl;
    exp_q.push_back(e);
    @(negedge CLK);
    compare(tag);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    ihit = 1'b1; dhit = 1'b0; cu_dREN = 1'b0; cu_dWEN = 1'b0; cu_halt = 1'b0;

    // Reset state, before and across a clock edge.
    #2;
    exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    compare("reset_pre_edge");
    @(negedge CLK);
    exp_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    compare("reset_held");
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // ALU ops: one pc_en per cycle, no stalls.
    for (int i = 0; i < 4; i++)
      cycle($sformatf("alu_%0d", i), 1, 0, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 0));

    // Load with dhit in the third DATA cycle; spurious ihit+halt in DATA.
    cycle("ld_ihit",  1, 0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
    cycle("ld_wait1", 0, 0, 0, 0, 0, mk(1, 1, 0, 0, 0, 0, 1, 1));
    cycle("ld_wait2", 1, 0, 0, 0, 1, mk(1, 1, 0, 0, 0, 0, 2, 2));
    cycle("ld_dhit",  0, 1, 0, 0, 0, mk(1, 1, 0, 1, 0, 0, 3, 3));
    cycle("ld_after", 1, 0, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 3, 3));

    // Store with immediate dhit, then a spurious dhit in RUN.
    cycle("st_ihit",  1, 0, 0, 1, 0, mk(1, 0, 0, 0, 0, 0, 3, 3));
    cycle("st_dhit",  0, 1, 0, 0, 0, mk(1, 0, 1, 1, 0, 0, 4, 4));
    cycle("spur_dhit", 0, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 4, 4));

    // Load and store together: read wins and the protocol error sticks.
    cycle("both_ihit", 1, 0, 1, 1, 0, mk(1, 0, 0, 0, 0, 0, 5, 5));
    cycle("both_data", 0, 0, 0, 0, 0, mk(1, 1, 0, 0, 0, 1, 6, 6));
    // Asynchronous reset between edges while in DATA.
    ihit = 1'b0; dhit = 1'b0;
    @(negedge CLK);
    exp_q.push_back(mk(1, 1, 0, 0, 0, 1, 7, 7));
    compare("both_data_held");
    #1;
    nRST = 1'b0;
    #1;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    compare("async_reset");
    ihit = 1'b1;
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    cycle("post_reset_run", 1, 0, 0, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 0));

    // Stall for 20 cycles: the 4-bit counter saturates at 15.
    for (int k = 0; k < 20; k++)
      cycle($sformatf("stall_%0d", k), 0, 0, 0, 0, 0,
            mk(1, 0, 0, 0, 0, 0, k, (k > 15) ? 15 : k));

    // Halt wins over a simultaneous load; everything then freezes.
    cycle("halt_ihit", 1, 0, 1, 0, 1, mk(1, 0, 0, 0, 0, 0, 20, 15));
    for (int j = 0; j < 10; j++)
      cycle($sformatf("halted_%0d", j), j[0], ~j[0], j[1], j[0], 1,
            mk(0, 0, 0, 0, 1, 0, 21, 15));

    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
